// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap entry / mret sequencer.
// Qualifies timer/external interrupts against mstatus.MIE and mie, then issues
// the CSR writes (mepc, mcause, mstatus) one per cycle and redirects the PC.
// An mret restores mstatus and then redirects to mepc.
//
// Handshake: there is no ready/valid pairing here. The CSR write port is a
// fire-and-forget strobe (csr_we_o qualifies csr_addr_o/csr_wdata_o in the same
// cycle, with both held at zero when csr_we_o is low); redirect_o and flush_o
// are single-cycle pulses; stall_o is a level held for the whole sequence.
//
// Optional build macro: TRAP_VECTORED_EN enables vectored trap targets when
// mtvec mode bits are 2'b01. Without it the target is always the mtvec base.
module trap_sequencer #(
  parameter int DW    = 32,
  parameter int ADDRW = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             t_intr_i,
  input  logic             e_intr_i,
  input  logic             is_mret_i,
  input  logic [DW-1:0]    pc_i,
  input  logic [DW-1:0]    mstatus_i,
  input  logic [DW-1:0]    mie_i,
  input  logic [DW-1:0]    mtvec_i,
  input  logic [DW-1:0]    mepc_i,
  output logic             csr_we_o,
  output logic [ADDRW-1:0] csr_addr_o,
  output logic [DW-1:0]    csr_wdata_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic             redirect_o,
  output logic [DW-1:0]    redirect_pc_o
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SAVE_EPC    = 3'd1,
    SAVE_CAUSE  = 3'd2,
    SAVE_STATUS = 3'd3,
    TRAP_JUMP   = 3'd4,
    MRET_STATUS = 3'd5,
    MRET_JUMP   = 3'd6
  } state_t;

  localparam logic [DW-1:0]    CAUSE_EXT    = {1'b1, {(DW-5){1'b0}}, 4'hB};
  localparam logic [DW-1:0]    CAUSE_TMR    = {1'b1, {(DW-5){1'b0}}, 4'h7};
  localparam logic [ADDRW-1:0] ADDR_MSTATUS = ADDRW'(12'h300);
  localparam logic [ADDRW-1:0] ADDR_MEPC    = ADDRW'(12'h341);
  localparam logic [ADDRW-1:0] ADDR_MCAUSE  = ADDRW'(12'h342);

  // FSM state is visible hierarchically (dut.state) for checkers.
  state_t        state;
  state_t        state_next;
  logic [DW-1:0] saved_pc;
  logic [DW-1:0] saved_cause;

  logic          int_ext;
  logic          int_tmr;
  logic          take;
  logic          mret_req;
  logic          start_trap;
  logic [DW-1:0] trap_base;
  logic [DW-1:0] trap_target;
  logic          unused_bits;

  // Interrupt qualification; gated with reset so all outputs read 0 in reset.
  always_comb begin
    int_ext    = e_intr_i & mie_i[11];
    int_tmr    = t_intr_i & mie_i[7];
    take       = rst_ni & mstatus_i[3] & (int_ext | int_tmr);
    mret_req   = rst_ni & is_mret_i;
    start_trap = (state == IDLE) & take & ~mret_req;
  end

  // Trap target: mtvec base, optionally offset by 4*cause in vectored mode.
  always_comb begin
    trap_base = {mtvec_i[DW-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (mtvec_i[1:0] == 2'b01) begin
      trap_target = trap_base + {saved_cause[DW-3:0], 2'b00};
    end else begin
      trap_target = trap_base;
    end
`else
    trap_target = trap_base;
`endif
  end

  // Only the MIE/MTIE/MEIE bits of the inputs matter; the rest is ignored.
  assign unused_bits = ^{mie_i[DW-1:12], mie_i[10:8], mie_i[6:0], mtvec_i[1:0],
                         saved_cause[DW-1:DW-2]};

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch PC and cause when a trap is accepted; external wins over timer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      saved_pc    <= '0;
      saved_cause <= '0;
    end else if (start_trap) begin
      saved_pc    <= pc_i;
      saved_cause <= int_ext ? CAUSE_EXT : CAUSE_TMR;
    end
  end

  // Next-state and Moore outputs; flush and IDLE stall follow the request inputs.
  always_comb begin
    state_next    = state;
    csr_we_o      = 1'b0;
    csr_addr_o    = '0;
    csr_wdata_o   = '0;
    stall_o       = 1'b1;
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    case (state)
      IDLE: begin
        stall_o = 1'b0;
        if (mret_req) begin
          stall_o    = 1'b1;
          state_next = MRET_STATUS;
        end else if (take) begin
          stall_o    = 1'b1;
          flush_o    = 1'b1;
          state_next = SAVE_EPC;
        end
      end
      SAVE_EPC: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = ADDR_MEPC;
        csr_wdata_o = saved_pc;
        state_next  = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = ADDR_MCAUSE;
        csr_wdata_o = saved_cause;
        state_next  = SAVE_STATUS;
      end
      SAVE_STATUS: begin
        csr_we_o           = 1'b1;
        csr_addr_o         = ADDR_MSTATUS;
        csr_wdata_o        = mstatus_i;
        csr_wdata_o[7]     = mstatus_i[3];
        csr_wdata_o[3]     = 1'b0;
        csr_wdata_o[12:11] = 2'b11;
        state_next         = TRAP_JUMP;
      end
      TRAP_JUMP: begin
        redirect_o    = 1'b1;
        redirect_pc_o = trap_target;
        state_next    = IDLE;
      end
      MRET_STATUS: begin
        csr_we_o       = 1'b1;
        csr_addr_o     = ADDR_MSTATUS;
        csr_wdata_o    = mstatus_i;
        csr_wdata_o[3] = mstatus_i[7];
        csr_wdata_o[7] = 1'b1;
        state_next     = MRET_JUMP;
      end
      MRET_JUMP: begin
        redirect_o    = 1'b1;
        redirect_pc_o = mepc_i;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
